// File: rtl/aes_pkg.sv
// Shared AES-128 types and helpers for the byte-serial core.
package aes_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      ROUND = 2'd1,
      OUT   = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      logic [7:0] v;
      case (rnd)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Byte i of the state sits at [127-8i -: 8]; row r, column c is i = r + 4c.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_8_bit_sbox.sv
// AES forward S-box, purely combinational 256-entry lookup.
module aes_sbox (
   input  logic [7:0] i_a,
   output logic [7:0] o_s
);

   always_comb begin
      o_s = 8'h00;
      case (i_a)
         8'h00: o_s = 8'h63; 8'h01: o_s = 8'h7c; 8'h02: o_s = 8'h77; 8'h03: o_s = 8'h7b;
         8'h04: o_s = 8'hf2; 8'h05: o_s = 8'h6b; 8'h06: o_s = 8'h6f; 8'h07: o_s = 8'hc5;
         8'h08: o_s = 8'h30; 8'h09: o_s = 8'h01; 8'h0a: o_s = 8'h67; 8'h0b: o_s = 8'h2b;
         8'h0c: o_s = 8'hfe; 8'h0d: o_s = 8'hd7; 8'h0e: o_s = 8'hab; 8'h0f: o_s = 8'h76;
         8'h10: o_s = 8'hca; 8'h11: o_s = 8'h82; 8'h12: o_s = 8'hc9; 8'h13: o_s = 8'h7d;
         8'h14: o_s = 8'hfa; 8'h15: o_s = 8'h59; 8'h16: o_s = 8'h47; 8'h17: o_s = 8'hf0;
         8'h18: o_s = 8'had; 8'h19: o_s = 8'hd4; 8'h1a: o_s = 8'ha2; 8'h1b: o_s = 8'haf;
         8'h1c: o_s = 8'h9c; 8'h1d: o_s = 8'ha4; 8'h1e: o_s = 8'h72; 8'h1f: o_s = 8'hc0;
         8'h20: o_s = 8'hb7; 8'h21: o_s = 8'hfd; 8'h22: o_s = 8'h93; 8'h23: o_s = 8'h26;
         8'h24: o_s = 8'h36; 8'h25: o_s = 8'h3f; 8'h26: o_s = 8'hf7; 8'h27: o_s = 8'hcc;
         8'h28: o_s = 8'h34; 8'h29: o_s = 8'ha5; 8'h2a: o_s = 8'he5; 8'h2b: o_s = 8'hf1;
         8'h2c: o_s = 8'h71; 8'h2d: o_s = 8'hd8; 8'h2e: o_s = 8'h31; 8'h2f: o_s = 8'h15;
         8'h30: o_s = 8'h04; 8'h31: o_s = 8'hc7; 8'h32: o_s = 8'h23; 8'h33: o_s = 8'hc3;
         8'h34: o_s = 8'h18; 8'h35: o_s = 8'h96; 8'h36: o_s = 8'h05; 8'h37: o_s = 8'h9a;
         8'h38: o_s = 8'h07; 8'h39: o_s = 8'h12; 8'h3a: o_s = 8'h80; 8'h3b: o_s = 8'he2;
         8'h3c: o_s = 8'heb; 8'h3d: o_s = 8'h27; 8'h3e: o_s = 8'hb2; 8'h3f: o_s = 8'h75;
         8'h40: o_s = 8'h09; 8'h41: o_s = 8'h83; 8'h42: o_s = 8'h2c; 8'h43: o_s = 8'h1a;
         8'h44: o_s = 8'h1b; 8'h45: o_s = 8'h6e; 8'h46: o_s = 8'h5a; 8'h47: o_s = 8'ha0;
         8'h48: o_s = 8'h52; 8'h49: o_s = 8'h3b; 8'h4a: o_s = 8'hd6; 8'h4b: o_s = 8'hb3;
         8'h4c: o_s = 8'h29; 8'h4d: o_s = 8'he3; 8'h4e: o_s = 8'h2f; 8'h4f: o_s = 8'h84;
         8'h50: o_s = 8'h53; 8'h51: o_s = 8'hd1; 8'h52: o_s = 8'h00; 8'h53: o_s = 8'hed;
         8'h54: o_s = 8'h20; 8'h55: o_s = 8'hfc; 8'h56: o_s = 8'hb1; 8'h57: o_s = 8'h5b;
         8'h58: o_s = 8'h6a; 8'h59: o_s = 8'hcb; 8'h5a: o_s = 8'hbe; 8'h5b: o_s = 8'h39;
         8'h5c: o_s = 8'h4a; 8'h5d: o_s = 8'h4c; 8'h5e: o_s = 8'h58; 8'h5f: o_s = 8'hcf;
         8'h60: o_s = 8'hd0; 8'h61: o_s = 8'hef; 8'h62: o_s = 8'haa; 8'h63: o_s = 8'hfb;
         8'h64: o_s = 8'h43; 8'h65: o_s = 8'h4d; 8'h66: o_s = 8'h33; 8'h67: o_s = 8'h85;
         8'h68: o_s = 8'h45; 8'h69: o_s = 8'hf9; 8'h6a: o_s = 8'h02; 8'h6b: o_s = 8'h7f;
         8'h6c: o_s = 8'h50; 8'h6d: o_s = 8'h3c; 8'h6e: o_s = 8'h9f; 8'h6f: o_s = 8'ha8;
         8'h70: o_s = 8'h51; 8'h71: o_s = 8'ha3; 8'h72: o_s = 8'h40; 8'h73: o_s = 8'h8f;
         8'h74: o_s = 8'h92; 8'h75: o_s = 8'h9d; 8'h76: o_s = 8'h38; 8'h77: o_s = 8'hf5;
         8'h78: o_s = 8'hbc; 8'h79: o_s = 8'hb6; 8'h7a: o_s = 8'hda; 8'h7b: o_s = 8'h21;
         8'h7c: o_s = 8'h10; 8'h7d: o_s = 8'hff; 8'h7e: o_s = 8'hf3; 8'h7f: o_s = 8'hd2;
         8'h80: o_s = 8'hcd; 8'h81: o_s = 8'h0c; 8'h82: o_s = 8'h13; 8'h83: o_s = 8'hec;
         8'h84: o_s = 8'h5f; 8'h85: o_s = 8'h97; 8'h86: o_s = 8'h44; 8'h87: o_s = 8'h17;
         8'h88: o_s = 8'hc4; 8'h89: o_s = 8'ha7; 8'h8a: o_s = 8'h7e; 8'h8b: o_s = 8'h3d;
         8'h8c: o_s = 8'h64; 8'h8d: o_s = 8'h5d; 8'h8e: o_s = 8'h19; 8'h8f: o_s = 8'h73;
         8'h90: o_s = 8'h60; 8'h91: o_s = 8'h81; 8'h92: o_s = 8'h4f; 8'h93: o_s = 8'hdc;
         8'h94: o_s = 8'h22; 8'h95: o_s = 8'h2a; 8'h96: o_s = 8'h90; 8'h97: o_s = 8'h88;
         8'h98: o_s = 8'h46; 8'h99: o_s = 8'hee; 8'h9a: o_s = 8'hb8; 8'h9b: o_s = 8'h14;
         8'h9c: o_s = 8'hde; 8'h9d: o_s = 8'h5e; 8'h9e: o_s = 8'h0b; 8'h9f: o_s = 8'hdb;
         8'ha0: o_s = 8'he0; 8'ha1: o_s = 8'h32; 8'ha2: o_s = 8'h3a; 8'ha3: o_s = 8'h0a;
         8'ha4: o_s = 8'h49; 8'ha5: o_s = 8'h06; 8'ha6: o_s = 8'h24; 8'ha7: o_s = 8'h5c;
         8'ha8: o_s = 8'hc2; 8'ha9: o_s = 8'hd3; 8'haa: o_s = 8'hac; 8'hab: o_s = 8'h62;
         8'hac: o_s = 8'h91; 8'had: o_s = 8'h95; 8'hae: o_s = 8'he4; 8'haf: o_s = 8'h79;
         8'hb0: o_s = 8'he7; 8'hb1: o_s = 8'hc8; 8'hb2: o_s = 8'h37; 8'hb3: o_s = 8'h6d;
         8'hb4: o_s = 8'h8d; 8'hb5: o_s = 8'hd5; 8'hb6: o_s = 8'h4e; 8'hb7: o_s = 8'ha9;
         8'hb8: o_s = 8'h6c; 8'hb9: o_s = 8'h56; 8'hba: o_s = 8'hf4; 8'hbb: o_s = 8'hea;
         8'hbc: o_s = 8'h65; 8'hbd: o_s = 8'h7a; 8'hbe: o_s = 8'hae; 8'hbf: o_s = 8'h08;
         8'hc0: o_s = 8'hba; 8'hc1: o_s = 8'h78; 8'hc2: o_s = 8'h25; 8'hc3: o_s = 8'h2e;
         8'hc4: o_s = 8'h1c; 8'hc5: o_s = 8'ha6; 8'hc6: o_s = 8'hb4; 8'hc7: o_s = 8'hc6;
         8'hc8: o_s = 8'he8; 8'hc9: o_s = 8'hdd; 8'hca: o_s = 8'h74; 8'hcb: o_s = 8'h1f;
         8'hcc: o_s = 8'h4b; 8'hcd: o_s = 8'hbd; 8'hce: o_s = 8'h8b; 8'hcf: o_s = 8'h8a;
         8'hd0: o_s = 8'h70; 8'hd1: o_s = 8'h3e; 8'hd2: o_s = 8'hb5; 8'hd3: o_s = 8'h66;
         8'hd4: o_s = 8'h48; 8'hd5: o_s = 8'h03; 8'hd6: o_s = 8'hf6; 8'hd7: o_s = 8'h0e;
         8'hd8: o_s = 8'h61; 8'hd9: o_s = 8'h35; 8'hda: o_s = 8'h57; 8'hdb: o_s = 8'hb9;
         8'hdc: o_s = 8'h86; 8'hdd: o_s = 8'hc1; 8'hde: o_s = 8'h1d; 8'hdf: o_s = 8'h9e;
         8'he0: o_s = 8'he1; 8'he1: o_s = 8'hf8; 8'he2: o_s = 8'h98; 8'he3: o_s = 8'h11;
         8'he4: o_s = 8'h69; 8'he5: o_s = 8'hd9; 8'he6: o_s = 8'h8e; 8'he7: o_s = 8'h94;
         8'he8: o_s = 8'h9b; 8'he9: o_s = 8'h1e; 8'hea: o_s = 8'h87; 8'heb: o_s = 8'he9;
         8'hec: o_s = 8'hce; 8'hed: o_s = 8'h55; 8'hee: o_s = 8'h28; 8'hef: o_s = 8'hdf;
         8'hf0: o_s = 8'h8c; 8'hf1: o_s = 8'ha1; 8'hf2: o_s = 8'h89; 8'hf3: o_s = 8'h0d;
         8'hf4: o_s = 8'hbf; 8'hf5: o_s = 8'he6; 8'hf6: o_s = 8'h42; 8'hf7: o_s = 8'h68;
         8'hf8: o_s = 8'h41; 8'hf9: o_s = 8'h99; 8'hfa: o_s = 8'h2d; 8'hfb: o_s = 8'h0f;
         8'hfc: o_s = 8'hb0; 8'hfd: o_s = 8'h54; 8'hfe: o_s = 8'hbb; 8'hff: o_s = 8'h16;
         default: o_s = 8'h00;
      endcase
   end

endmodule

// File: rtl/aes_8_bit.sv
// Byte-serial AES-128 encrypt core: 16-byte load, one round per clock,
// 16-byte registered ciphertext readout, then idle until reset.
module aes_8_bit
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] key_in,
   input  logic [7:0] d_in,
   output logic [7:0] d_out,
   output logic       d_vld
);

   state_t         r_fsm;
   state_t         w_fsm_nxt;
   logic [3:0]     r_cnt;
   logic [3:0]     r_round;
   logic [127:0]   r_key;
   logic [127:0]   r_data;
   logic [7:0]     r_dout;
   logic           r_vld;

   logic [127:0]   w_key_shift;
   logic [127:0]   w_data_shift;
   logic [127:0]   w_sub;
   logic [127:0]   w_sr;
   logic [127:0]   w_mc;
   logic [127:0]   w_next_key;
   logic [127:0]   w_round_out;
   logic [31:0]    w_rot;
   logic [31:0]    w_subw;
   logic [31:0]    w_temp;
   logic [31:0]    w_k0, w_k1, w_k2, w_k3;

   assign w_key_shift  = {r_key[119:0], key_in};
   assign w_data_shift = {r_data[119:0], d_in};

   for (genvar gi = 0; gi < 16; gi++) begin : g_sub
      aes_sbox u_sbox (
         .i_a (r_data[127-8*gi -: 8]),
         .o_s (w_sub[127-8*gi -: 8])
      );
   end

   assign w_rot = {r_key[23:0], r_key[31:24]};

   for (genvar gk = 0; gk < 4; gk++) begin : g_subw
      aes_sbox u_sbox (
         .i_a (w_rot[31-8*gk -: 8]),
         .o_s (w_subw[31-8*gk -: 8])
      );
   end

   // Next round key is formed in the same cycle it is applied.
   assign w_temp     = w_subw ^ {rcon(r_round), 24'h0};
   assign w_k0       = r_key[127:96] ^ w_temp;
   assign w_k1       = r_key[95:64] ^ w_k0;
   assign w_k2       = r_key[63:32] ^ w_k1;
   assign w_k3       = r_key[31:0] ^ w_k2;
   assign w_next_key = {w_k0, w_k1, w_k2, w_k3};

   assign w_sr = shift_rows(w_sub);
   assign w_mc = {mix_column(w_sr[127:96]), mix_column(w_sr[95:64]),
                  mix_column(w_sr[63:32]),  mix_column(w_sr[31:0])};

   assign w_round_out = ((r_round == 4'd10) ? w_sr : w_mc) ^ w_next_key;

   always_comb begin
      w_fsm_nxt = r_fsm;
      case (r_fsm)
         LOAD:    if (r_cnt == 4'd15)    w_fsm_nxt = ROUND;
         ROUND:   if (r_round == 4'd10)  w_fsm_nxt = OUT;
         OUT:     if (r_cnt == 4'd15)    w_fsm_nxt = DONE;
         DONE:    w_fsm_nxt = DONE;
         default: w_fsm_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm   <= LOAD;
         r_cnt   <= 4'd0;
         r_round <= 4'd0;
         r_key   <= '0;
         r_data  <= '0;
         r_dout  <= 8'h00;
         r_vld   <= 1'b0;
      end else begin
         r_fsm <= w_fsm_nxt;
         case (r_fsm)
            LOAD: begin
               r_key <= w_key_shift;
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == 4'd15) begin
                  r_data  <= w_data_shift ^ w_key_shift;
                  r_round <= 4'd1;
               end else begin
                  r_data  <= w_data_shift;
               end
            end
            ROUND: begin
               r_key   <= w_next_key;
               r_data  <= w_round_out;
               r_round <= r_round + 4'd1;
               r_cnt   <= 4'd0;
            end
            OUT: begin
               r_dout <= r_data[127:120];
               r_vld  <= 1'b1;
               r_data <= {r_data[119:0], 8'h00};
               r_cnt  <= r_cnt + 4'd1;
            end
            default: begin
               r_dout <= 8'h00;
               r_vld  <= 1'b0;
            end
         endcase
      end
   end

   assign d_out = r_dout;
   assign d_vld = r_vld;

endmodule

// File: tb/tb_aes_8_bit.sv
// Scoreboard bench for aes_8_bit: FIPS vectors plus random blocks
// checked against a byte-array AES model built from GF(2^8) arithmetic.
module tb_aes_8_bit;

   logic       clk;
   logic       rst;
   logic [7:0] key_in;
   logic [7:0] d_in;
   logic [7:0] d_out;
   logic       d_vld;

   int checks;
   int failures;

   logic [7:0] exp_q[$];
   logic [7:0] ref_sbox[256];

   aes_8_bit dut (
      .clk    (clk),
      .rst    (rst),
      .key_in (key_in),
      .d_in   (d_in),
      .d_out  (d_out),
      .d_vld  (d_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // S-box from its definition: multiplicative inverse then affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         ref_sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
      logic [7:0] st[16];
      logic [7:0] tmp[16];
      logic [7:0] rk[176];
      logic [7:0] t[4];
      logic [7:0] t0;
      logic [7:0] rc;
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] ct;
      for (int i = 0; i < 16; i++) begin
         rk[i] = key[127-8*i -: 8];
         st[i] = pt[127-8*i -: 8];
      end
      rc = 8'h01;
      for (int i = 16; i < 176; i += 4) begin
         for (int j = 0; j < 4; j++) t[j] = rk[i-4+j];
         if (i % 16 == 0) begin
            t0 = t[0]; t[0] = t[1]; t[1] = t[2]; t[2] = t[3]; t[3] = t0;
            for (int j = 0; j < 4; j++) t[j] = ref_sbox[t[j]];
            t[0] = t[0] ^ rc;
            rc = gf_mul(rc, 8'h02);
         end
         for (int j = 0; j < 4; j++) rk[i+j] = rk[i-16+j] ^ t[j];
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[i];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) st[i] = ref_sbox[st[i]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) tmp[w+4*c] = st[w+4*((c+w)%4)];
         for (int i = 0; i < 16; i++) st[i] = tmp[i];
         if (r != 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
               st[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
               st[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
               st[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
               st[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
            end
         end
         for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[16*r+i];
      end
      for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = st[i];
      return ct;
   endfunction

   // Monitor: every cycle either a scoreboard byte or an idle zero output.
   always @(negedge clk) begin
      logic [7:0] want;
      checks++;
      if (d_vld) begin
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_vld got=%02h want=no_output t=%0t", d_out, $time);
         end else begin
            want = exp_q.pop_front();
            if (d_out !== want) begin
               failures++;
               $display("FAIL ct_byte got=%02h want=%02h t=%0t", d_out, want, $time);
            end
         end
      end else if (d_out !== 8'h00) begin
         failures++;
         $display("FAIL idle_dout got=%02h want=00 t=%0t", d_out, $time);
      end
   end

   task automatic check_vld(input string name, input logic want);
      checks++;
      if (d_vld !== want) begin
         failures++;
         $display("FAIL %s got=%b want=%b t=%0t", name, d_vld, want, $time);
      end
   endtask

   task automatic load(input logic [127:0] k, input logic [127:0] p,
                       input logic [127:0] ct, input bit push);
      for (int i = 0; i < 16; i++) begin
         key_in = k[127-8*i -: 8];
         d_in   = p[127-8*i -: 8];
         @(posedge clk);
         #1;
      end
      if (push) begin
         for (int i = 0; i < 16; i++) exp_q.push_back(ct[127-8*i -: 8]);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout got=%0d_left want=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic pulse_rst(input int n);
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] rk;
      logic [127:0] rp;
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      key_in   = 8'h00;
      d_in     = 8'h00;
      build_sbox();

      // Long reset with busy inputs: outputs must stay quiet.
      for (int i = 0; i < 6; i++) begin
         key_in = 8'($urandom);
         d_in   = 8'($urandom);
         @(posedge clk);
         #1;
         check_vld("reset_vld", 1'b0);
         checks++;
         if (d_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_dout got=%02h want=00", d_out);
         end
      end
      rst = 1'b0;
      load(K2, P2, C2, 1'b1);
      drain();

      // Vector 1, sit in DONE, reset, vector 2.
      pulse_rst(1);
      load(K1, P1, C1, 1'b1);
      drain();
      repeat (20) @(posedge clk);
      #1;
      pulse_rst(1);
      load(K2, P2, C2, 1'b1);
      drain();

      // All-zero block with exact strobe timing.
      pulse_rst(1);
      load('0, '0, C0, 1'b1);
      for (int e = 17; e <= 26; e++) begin
         @(posedge clk);
         #1;
         check_vld("lat_pre", 1'b0);
      end
      for (int e = 27; e <= 42; e++) begin
         @(posedge clk);
         #1;
         check_vld("lat_on", 1'b1);
      end
      for (int e = 0; e < 1100; e++) begin
         @(posedge clk);
         #1;
         check_vld("lat_off", 1'b0);
      end
      drain();

      // Abort mid-round; the aborted block must never appear.
      pulse_rst(1);
      load(K1, P1, C1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      pulse_rst(1);
      load(K1, P1, C1, 1'b1);
      drain();

      for (int n = 0; n < 8; n++) begin
         rk = {$urandom, $urandom, $urandom, $urandom};
         rp = {$urandom, $urandom, $urandom, $urandom};
         pulse_rst(1 + n % 3);
         load(rk, rp, aes_ref(rk, rp), 1'b1);
         drain();
      end

      repeat (5) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
